// File: rtl/morse_decoder.sv
// ---------------------------------------------------------------------------
// morse_decoder
//   Decodes a hand-keyed Morse signal into ASCII characters. Element and gap
//   lengths are measured in units of UNIT_CYCLES clocks on the synchronized key
//   level: a press of 1 unit is a dot, and 2 or more units is a dash. A silence
//   of 3 units ends a character. Up to six elements form one character.
//
//   Optional feature: define MORSE_WORD_SPACE_EN to emit a space (0x20) after
//   7 units of silence following a decoded character.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-low reset
//   key_n        asynchronous Morse key, active-low (pressed = 0)
//   ascii_out    decoded character, held until the next strobe
//   ascii_valid  one-clock strobe qualifying ascii_out
//   err_pulse    one-clock strobe when a seventh element overflows the pattern
//   led_n        active-low echo of the synchronized key
// ---------------------------------------------------------------------------
module morse_decoder #(
    parameter int UNIT_CYCLES = 4_800_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    output logic       err_pulse,
    output logic       led_n
);

    localparam int               SUB_W      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(UNIT_CYCLES - 1);
    localparam logic [2:0]       UNITS_MAX  = 3'd7;
    localparam logic [2:0]       GAP_UNITS  = 3'd3;
    localparam logic [2:0]       WORD_UNITS = 3'd7;
    localparam logic [2:0]       MAX_ELEMS  = 3'd6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MARK = 3'd1,
        GAP  = 3'd2,
        WORD = 3'd3,
        LOCK = 3'd4
    } state_e;

    // Lookup keyed on {length, pattern}; the pattern is right-aligned with the
    // first element in the most significant valid bit, and 1 means dash.
    function automatic logic [7:0] decode_char(input logic [2:0] len, input logic [5:0] pat);
        logic [7:0] ch;
        case ({len, pat})
            9'b001_000000: ch = 8'h45; // E
            9'b001_000001: ch = 8'h54; // T
            9'b010_000001: ch = 8'h41; // A
            9'b010_000000: ch = 8'h49; // I
            9'b010_000011: ch = 8'h4D; // M
            9'b010_000010: ch = 8'h4E; // N
            9'b011_000100: ch = 8'h44; // D
            9'b011_000110: ch = 8'h47; // G
            9'b011_000101: ch = 8'h4B; // K
            9'b011_000111: ch = 8'h4F; // O
            9'b011_000010: ch = 8'h52; // R
            9'b011_000000: ch = 8'h53; // S
            9'b011_000001: ch = 8'h55; // U
            9'b011_000011: ch = 8'h57; // W
            9'b100_001000: ch = 8'h42; // B
            9'b100_001010: ch = 8'h43; // C
            9'b100_000010: ch = 8'h46; // F
            9'b100_000000: ch = 8'h48; // H
            9'b100_000111: ch = 8'h4A; // J
            9'b100_000100: ch = 8'h4C; // L
            9'b100_000110: ch = 8'h50; // P
            9'b100_001101: ch = 8'h51; // Q
            9'b100_000001: ch = 8'h56; // V
            9'b100_001001: ch = 8'h58; // X
            9'b100_001011: ch = 8'h59; // Y
            9'b100_001100: ch = 8'h5A; // Z
            9'b101_011111: ch = 8'h30; // 0
            9'b101_001111: ch = 8'h31; // 1
            9'b101_000111: ch = 8'h32; // 2
            9'b101_000011: ch = 8'h33; // 3
            9'b101_000001: ch = 8'h34; // 4
            9'b101_000000: ch = 8'h35; // 5
            9'b101_010000: ch = 8'h36; // 6
            9'b101_011000: ch = 8'h37; // 7
            9'b101_011100: ch = 8'h38; // 8
            9'b101_011110: ch = 8'h39; // 9
            9'b101_010010: ch = 8'h2F; // /
            9'b101_010001: ch = 8'h3D; // =
            9'b110_010101: ch = 8'h2E; // .
            9'b110_110011: ch = 8'h2C; // ,
            9'b110_001100: ch = 8'h3F; // ?
            default:       ch = 8'h23; // #
        endcase
        return ch;
    endfunction

    logic             key_meta_q, key_meta_d;
    logic             key_sync_q, key_sync_d;
    logic             key_prev_q, key_prev_d;
    logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
    logic [2:0]       unit_cnt_q, unit_cnt_d;
    state_e           state_q, state_d;
    state_e           prev_state_q, prev_state_d;
    logic [5:0]       pattern_q, pattern_d;
    logic [2:0]       len_q, len_d;
    logic [7:0]       ascii_out_q, ascii_out_d;
    logic             ascii_valid_q, ascii_valid_d;
    logic             err_pulse_q, err_pulse_d;

    logic             edge_s;
    logic             press_s;
    logic             release_s;
    logic             wrap_s;
    logic [2:0]       units_now_s;
    state_e           gap_exit_s;

    // Synchronizer pipeline plus one extra stage for edge detection.
    always_comb begin
        key_meta_d = key_n;
        key_sync_d = key_meta_q;
        key_prev_d = key_sync_q;
    end

    assign edge_s    = key_sync_q ^ key_prev_q;
    assign press_s   = edge_s & ~key_sync_q;
    assign release_s = edge_s & key_sync_q;
    assign wrap_s    = (sub_cnt_q == SUB_LAST);

    // Units completed so far, counting a wrap happening in this very clock, so
    // an interval of N clocks measures floor(N / UNIT_CYCLES) units.
    assign units_now_s = (unit_cnt_q == UNITS_MAX) ? UNITS_MAX : (unit_cnt_q + {2'b00, wrap_s});

    // After a character gap, a decoded character leads to WORD; an empty
    // (overflowed) pattern behaves as if nothing was keyed.
    assign gap_exit_s = (len_q != 3'd0) ? WORD : IDLE;

    // Unit timing: restart on every key edge, saturate the unit count.
    always_comb begin
        sub_cnt_d  = sub_cnt_q;
        unit_cnt_d = unit_cnt_q;
        if (edge_s) begin
            sub_cnt_d  = {SUB_W{1'b0}};
            unit_cnt_d = 3'd0;
        end else if (wrap_s) begin
            sub_cnt_d  = {SUB_W{1'b0}};
            unit_cnt_d = units_now_s;
        end else begin
            sub_cnt_d  = sub_cnt_q + SUB_W'(1);
            unit_cnt_d = unit_cnt_q;
        end
    end

    // Decoder FSM: next state, pattern accumulation and output strobes.
    always_comb begin
        state_d       = state_q;
        prev_state_d  = prev_state_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        ascii_out_d   = ascii_out_q;
        ascii_valid_d = 1'b0;
        err_pulse_d   = 1'b0;
        case (state_q)
            LOCK: begin
                // Wait for a full unit of released key so a key held through
                // reset cannot register as a press once synchronized.
                if (key_sync_q && (units_now_s >= 3'd1)) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK;
                end
            end
            IDLE: begin
                if (press_s) begin
                    prev_state_d = IDLE;
                    state_d      = MARK;
                end else begin
                    state_d = IDLE;
                end
            end
            MARK: begin
                if (release_s) begin
                    if (units_now_s == 3'd0) begin
                        state_d = prev_state_q;
                    end else if (len_q == MAX_ELEMS) begin
                        err_pulse_d = 1'b1;
                        pattern_d   = 6'b000000;
                        len_d       = 3'd0;
                        state_d     = GAP;
                    end else begin
                        pattern_d = {pattern_q[4:0], (units_now_s >= 3'd2)};
                        len_d     = len_q + 3'd1;
                        state_d   = GAP;
                    end
                end else begin
                    state_d = MARK;
                end
            end
            GAP: begin
                if (units_now_s >= GAP_UNITS) begin
                    if (len_q != 3'd0) begin
                        ascii_out_d   = decode_char(len_q, pattern_q);
                        ascii_valid_d = 1'b1;
                    end else begin
                        ascii_valid_d = 1'b0;
                    end
                    pattern_d = 6'b000000;
                    len_d     = 3'd0;
                    if (press_s) begin
                        prev_state_d = gap_exit_s;
                        state_d      = MARK;
                    end else begin
                        state_d = gap_exit_s;
                    end
                end else if (press_s) begin
                    prev_state_d = GAP;
                    state_d      = MARK;
                end else begin
                    state_d = GAP;
                end
            end
            WORD: begin
                if (units_now_s >= WORD_UNITS) begin
`ifdef MORSE_WORD_SPACE_EN
                    ascii_out_d   = 8'h20;
                    ascii_valid_d = 1'b1;
`endif
                    if (press_s) begin
                        prev_state_d = IDLE;
                        state_d      = MARK;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (press_s) begin
                    prev_state_d = WORD;
                    state_d      = MARK;
                end else begin
                    state_d = WORD;
                end
            end
            default: begin
                state_d = LOCK;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_meta_q    <= 1'b1;
            key_sync_q    <= 1'b1;
            key_prev_q    <= 1'b1;
            sub_cnt_q     <= {SUB_W{1'b0}};
            unit_cnt_q    <= 3'd0;
            state_q       <= LOCK;
            prev_state_q  <= IDLE;
            pattern_q     <= 6'b000000;
            len_q         <= 3'd0;
            ascii_out_q   <= 8'h00;
            ascii_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
        end else begin
            key_meta_q    <= key_meta_d;
            key_sync_q    <= key_sync_d;
            key_prev_q    <= key_prev_d;
            sub_cnt_q     <= sub_cnt_d;
            unit_cnt_q    <= unit_cnt_d;
            state_q       <= state_d;
            prev_state_q  <= prev_state_d;
            pattern_q     <= pattern_d;
            len_q         <= len_d;
            ascii_out_q   <= ascii_out_d;
            ascii_valid_q <= ascii_valid_d;
            err_pulse_q   <= err_pulse_d;
        end
    end

    assign ascii_out   = ascii_out_q;
    assign ascii_valid = ascii_valid_q;
    assign err_pulse   = err_pulse_q;
    assign led_n       = key_sync_q;

endmodule

// File: tb/tb_morse_decoder.sv
`timescale 1ns/1ps
module tb_morse_decoder;
    localparam int U = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       err_pulse;
    logic       led_n;

    always #5 clk = ~clk;

    morse_decoder #(.UNIT_CYCLES(U)) dut (
        .clk(clk),
        .rst(rst),
        .key_n(key_n),
        .ascii_out(ascii_out),
        .ascii_valid(ascii_valid),
        .err_pulse(err_pulse),
        .led_n(led_n)
    );

`ifdef MORSE_WORD_SPACE_EN
    bit word_space = 1'b1;
`else
    bit word_space = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference code table: one Morse string per character.
    string tab_chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789.,?/=";
    string tab_code [0:40] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
        ".-.-.-", "--..--", "..--..", "-..-.", "-...-"
    };

    // Observed output stream captured away from the active edge.
    byte  got_q[$];
    int   got_cyc_q[$];
    int   err_seen = 0;
    int   dbl_valid = 0;
    int   hold_viol = 0;
    logic prev_valid = 1'b0;
    logic [7:0] last_out = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            last_out   = 8'h00;
        end else begin
            if (ascii_valid) begin
                got_q.push_back(ascii_out);
                got_cyc_q.push_back(cyc);
                if (prev_valid) dbl_valid++;
                last_out = ascii_out;
            end else if (ascii_out !== last_out) begin
                hold_viol++;
            end
            if (err_pulse) err_seen++;
            prev_valid = ascii_valid;
        end
    end

    // Reference model state.
    byte   exp_q[$];
    int    exp_err = 0;
    string cur = "";
    int    last_rel = 0;

    function automatic byte lookup(input string pat);
        string chars_v;
        chars_v = tab_chars;
        for (int i = 0; i <= 40; i++) begin
            if (tab_code[i] == pat) return chars_v[i];
        end
        return 8'h23;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one press/release pair and advance the model by the same rules:
    // units = press/U (max 7); 0 units ignored, 1 dot, >=2 dash; a seventh
    // element flags an error and empties the pattern; silence of >= 3U ends the
    // character, >= 7U also ends the word.
    task automatic elem(input int press_len, input int gap_len);
        int units;
        key_n = 1'b0;
        wait_cycles(press_len);
        key_n = 1'b1;
        last_rel = cyc;
        wait_cycles(gap_len);
        units = press_len / U;
        if (units > 7) units = 7;
        if (units >= 1) begin
            if (cur.len() == 6) begin
                exp_err++;
                cur = "";
            end else if (units >= 2) begin
                cur = {cur, "-"};
            end else begin
                cur = {cur, "."};
            end
        end
        if (gap_len >= 3 * U) begin
            if (cur.len() > 0) begin
                exp_q.push_back(lookup(cur));
                if (word_space && gap_len >= 7 * U) exp_q.push_back(8'h20);
            end
            cur = "";
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_char%0d", tag, i), got_q[i], exp_q[i]);
        end
        check({tag, "_err"}, err_seen, exp_err);
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        err_seen = 0;
        exp_err  = 0;
    endtask

    initial begin
        int    idx;
        int    gap;
        string code;
        byte   sym;

        // Reset with the key already pressed.
        rst   = 1'b0;
        key_n = 1'b0;
        wait_cycles(4);
        check("rst_ascii_out", ascii_out, 8'h00);
        check("rst_ascii_valid", ascii_valid, 1'b0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_led_n", led_n, 1'b1);

        // Key held across reset release, then let go: nothing may come out.
        rst = 1'b1;
        wait_cycles(50);
        check("held_led_n", led_n, 1'b0);
        key_n = 1'b1;
        wait_cycles(40);
        check("released_led_n", led_n, 1'b1);
        check_stream("lock");

        // Single dot 'E' and its strobe latency (2 sync + 3 units + register).
        elem(15, 100);
        check("e_latency", (got_cyc_q.size() > 0) ? (got_cyc_q[0] - last_rel) : -1, 3 * U + 3);
        check("e_held_out", ascii_out, word_space ? 8'h20 : 8'h45);
        check_stream("e");

        // 'A'.
        elem(12, 12);
        elem(35, 40);
        check_stream("a");

        // Six dashes: unknown pattern.
        repeat (5) elem(25, 15);
        elem(25, 60);
        check_stream("six_dash");

        // Seven dots: overflow.
        repeat (6) elem(15, 12);
        elem(15, 60);
        check_stream("seven_dot");

        // Glitch press from IDLE, then a normal character still decodes.
        elem(5, 60);
        elem(15, 60);
        check_stream("glitch");

        // Press exactly on the third gap-unit boundary.
        elem(15, 3 * U);
        elem(35, 60);
        check_stream("gap_edge");

        // Long hold saturates as a dash; long silence stays quiet.
        elem(100, 200);
        check_stream("long_hold");

        // Reset in the middle of a dash after a pending dot.
        elem(15, 12);
        key_n = 1'b0;
        wait_cycles(25);
        rst = 1'b0;
        wait_cycles(3);
        rst = 1'b1;
        cur = "";
        wait_cycles(50);
        key_n = 1'b1;
        wait_cycles(100);
        check_stream("rst_mid");

        // Randomized characters with random element and gap timing.
        for (int c = 0; c < 12; c++) begin
            idx  = $urandom_range(0, 40);
            code = tab_code[idx];
            for (int j = 0; j < code.len(); j++) begin
                sym = code[j];
                if (j == code.len() - 1) begin
                    gap = ($urandom_range(0, 1) == 0) ? $urandom_range(3 * U, 7 * U - 1)
                                                      : $urandom_range(7 * U, 9 * U);
                end else begin
                    gap = $urandom_range(4, 3 * U - 1);
                end
                if (sym == 8'h2D) elem($urandom_range(2 * U, 5 * U), gap);
                else              elem($urandom_range(U, 2 * U - 1), gap);
            end
        end
        wait_cycles(100);
        check_stream("random");

        check("double_valid", dbl_valid, 0);
        check("hold_violation", hold_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
